// File: rtl/pipe_mult_unit_if.sv
// Operand/result bundle between the ALU (master) and the pipelined multiplier (slave).
interface pipe_mult_unit_if #(
  parameter int XLEN = 32
);
  logic                start;
  logic [1:0]          sign_mode;
  logic [XLEN-1:0]     mcand;
  logic [XLEN-1:0]     mplier;
  logic [2*XLEN-1:0]   product;
  logic                done;

  modport master (
    output start, sign_mode, mcand, mplier,
    input  product, done
  );

  modport slave (
    input  start, sign_mode, mcand, mplier,
    output product, done
  );
endinterface

// File: rtl/pipe_mult_unit.sv
// Pipelined XLEN x XLEN -> 2*XLEN multiplier, one BITS-wide multiplier digit per stage.
// Accepts an operation every cycle and returns it exactly NUM_STAGES cycles later.
module pipe_mult_unit #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4
) (
  input logic             clock,
  input logic             reset,
  pipe_mult_unit_if.slave bus
);

  localparam int W    = 2 * XLEN;
  localparam int BITS = W / NUM_STAGES;
  localparam int NREG = NUM_STAGES - 1;

  logic          mc_signed;
  logic          mp_signed;
  logic [W-1:0]  ext_mc;
  logic [W-1:0]  ext_mp;

  logic          valid_q [NREG];
  logic [W-1:0]  acc_q   [NREG];
  logic [W-1:0]  mc_q    [NREG];
  logic [W-1:0]  mp_q    [NREG];

  logic          in_valid [NUM_STAGES];
  logic [W-1:0]  in_acc   [NUM_STAGES];
  logic [W-1:0]  in_mc    [NUM_STAGES];
  logic [W-1:0]  in_mp    [NUM_STAGES];

  function automatic logic [W-1:0] low_digit(input logic [W-1:0] v);
    return {{(W-BITS){1'b0}}, v[BITS-1:0]};
  endfunction

  // Mode 2'b10 signs only the multiplicand; 2'b11 behaves as unsigned.
  assign mc_signed = (bus.sign_mode == 2'b01) || (bus.sign_mode == 2'b10);
  assign mp_signed = (bus.sign_mode == 2'b01);
  assign ext_mc    = {{XLEN{mc_signed & bus.mcand[XLEN-1]}},  bus.mcand};
  assign ext_mp    = {{XLEN{mp_signed & bus.mplier[XLEN-1]}}, bus.mplier};

  always_comb begin
    in_valid[0] = bus.start;
    in_acc[0]   = '0;
    in_mc[0]    = ext_mc;
    in_mp[0]    = ext_mp;
    for (int k = 1; k < NUM_STAGES; k++) begin
      in_valid[k] = valid_q[k-1];
      in_acc[k]   = acc_q[k-1];
      in_mc[k]    = mc_q[k-1];
      in_mp[k]    = mp_q[k-1];
    end
  end

  // By the last stage only the final BITS-wide digit of mp is left, so the full
  // multiply there equals the single-digit partial product.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) begin
        valid_q[k] <= 1'b0;
        acc_q[k]   <= '0;
        mc_q[k]    <= '0;
        mp_q[k]    <= '0;
      end
      bus.product <= '0;
      bus.done    <= 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        valid_q[k] <= in_valid[k];
        acc_q[k]   <= in_acc[k] + in_mc[k] * low_digit(in_mp[k]);
        mc_q[k]    <= in_mc[k] << BITS;
        mp_q[k]    <= in_mp[k] >> BITS;
      end
      bus.done <= in_valid[NREG];
      if (in_valid[NREG]) begin
        bus.product <= in_acc[NREG] + in_mc[NREG] * in_mp[NREG];
      end
    end
  end

endmodule
